// File: rtl/simd_pkg.sv
// SIMD execute-stage shared types and GF(2^8) helpers.
// Imported by the lane ALU and the execute stage.
package simd_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_SLL   = 3'd5,
    OP_ROTL  = 3'd6,
    OP_GFMUL = 3'd7
  } alu_op_e;

  typedef enum logic {
    EX_IDLE = 1'b0,
    EX_GF   = 1'b1
  } ex_state_e;

  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One combinational SIMD lane: add/sub/logic/shift/rotate.
// GF multiply is handled by the iterative engine in the stage.
import simd_pkg::*;

module simd_lane_alu #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  alu_op_e      op_i,
  output logic [W-1:0] y_o
);

  localparam int SW = $clog2(W);

  logic [SW-1:0] sh;

  assign sh = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLL:  y_o = a_i << sh;
      // a shift by W yields 0, so sh==0 rotates to a_i
      OP_ROTL: y_o = (a_i << sh) | (a_i >> (W - int'(sh)));
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/simd_ex_stage.sv
// SIMD execute stage: forwarding, lane ALUs, iterative GF(2^8)
// byte multiply and the registered EX/MEM output.
import simd_pkg::*;

module simd_ex_stage #(
  parameter int LANES  = 4,
  parameter int LANE_W = 16,
  parameter int NFW    = 3,
  parameter int CTRL_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          stall_in,
  input  logic                          flush,
  input  logic [LANES*LANE_W-1:0]       data1,
  input  logic [LANES*LANE_W-1:0]       data2,
  input  logic [LANES*LANE_W-1:0]       imm,
  input  logic [NFW*LANES*LANE_W-1:0]   fw_data,
  input  logic [$clog2(NFW+1)-1:0]      sel_fw_a,
  input  logic [$clog2(NFW+1)-1:0]      sel_fw_b,
  input  logic                          alu_src,
  input  logic [2:0]                    alu_op,
  input  logic [CTRL_W-1:0]             ctrl_in,
  output logic                          out_valid,
  output logic [LANES*LANE_W-1:0]       alu_result,
  output logic [LANES*LANE_W-1:0]       write_data,
  output logic [CTRL_W-1:0]             ctrl_out,
  output logic                          busy
);

  localparam int DW  = LANES * LANE_W;
  localparam int FSW = $clog2(NFW + 1);
  localparam int NB  = DW / 8;

  ex_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DW-1:0]     ga_q, ga_d, gb_q, gb_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [DW-1:0]     gwd_q, gwd_d;
  logic [CTRL_W-1:0] gctrl_q, gctrl_d;
  logic              ov_q, ov_d;
  logic [DW-1:0]     res_q, res_d, wd_q, wd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  alu_op_e       op;
  logic          accept;
  logic [DW-1:0] op_a, b_fw, op_b, alu_y;
  logic [DW-1:0] ga_s, gb_s, acc_s;

  assign op     = alu_op_e'(alu_op);
  assign busy   = (state_q == EX_GF);
  assign accept = in_valid & ~busy & ~stall_in & ~flush;

  // out-of-range selects fall through to zero
  always_comb begin
    op_a = (sel_fw_a == '0) ? data1 : '0;
    b_fw = (sel_fw_b == '0) ? data2 : '0;
    for (int k = 1; k <= NFW; k++) begin
      if (sel_fw_a == FSW'(k)) op_a = fw_data[(k-1)*DW +: DW];
      if (sel_fw_b == FSW'(k)) b_fw = fw_data[(k-1)*DW +: DW];
    end
    op_b = alu_src ? imm : b_fw;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_lane_alu #(.W(LANE_W)) u_lane (
      .a_i (op_a[g*LANE_W +: LANE_W]),
      .b_i (op_b[g*LANE_W +: LANE_W]),
      .op_i(op),
      .y_o (alu_y[g*LANE_W +: LANE_W])
    );
  end

  // one shift-and-add step per byte
  always_comb begin
    ga_s  = '0;
    gb_s  = '0;
    acc_s = '0;
    for (int i = 0; i < NB; i++) begin
      acc_s[i*8 +: 8] = acc_q[i*8 +: 8]
                      ^ (gb_q[i*8] ? ga_q[i*8 +: 8] : 8'h00);
      ga_s[i*8 +: 8]  = xtime(ga_q[i*8 +: 8]);
      gb_s[i*8 +: 8]  = {1'b0, gb_q[i*8+1 +: 7]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ga_d    = ga_q;
    gb_d    = gb_q;
    acc_d   = acc_q;
    gwd_d   = gwd_q;
    gctrl_d = gctrl_q;
    ov_d    = ov_q;
    res_d   = res_q;
    wd_d    = wd_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      ov_d    = 1'b0;
      state_d = EX_IDLE;
      cnt_d   = '0;
    end else if (stall_in) begin
      ov_d = ov_q;
    end else if (state_q == EX_GF) begin
      ga_d  = ga_s;
      gb_d  = gb_s;
      acc_d = acc_s;
      cnt_d = cnt_q + 3'd1;
      ov_d  = 1'b0;
      if (cnt_q == 3'd7) begin
        res_d   = acc_s;
        wd_d    = gwd_q;
        ctrl_d  = gctrl_q;
        ov_d    = 1'b1;
        state_d = EX_IDLE;
        cnt_d   = '0;
      end
    end else if (accept) begin
      if (op == OP_GFMUL) begin
        ga_d    = op_a;
        gb_d    = op_b;
        gwd_d   = b_fw;
        gctrl_d = ctrl_in;
        acc_d   = '0;
        cnt_d   = '0;
        ov_d    = 1'b0;
        state_d = EX_GF;
      end else begin
        res_d  = alu_y;
        wd_d   = b_fw;
        ctrl_d = ctrl_in;
        ov_d   = 1'b1;
      end
    end else begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EX_IDLE;
      cnt_q   <= '0;
      ga_q    <= '0;
      gb_q    <= '0;
      acc_q   <= '0;
      gwd_q   <= '0;
      gctrl_q <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      wd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ga_q    <= ga_d;
      gb_q    <= gb_d;
      acc_q   <= acc_d;
      gwd_q   <= gwd_d;
      gctrl_q <= gctrl_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      wd_q    <= wd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid  = ov_q;
  assign alu_result = res_q;
  assign write_data = wd_q;
  assign ctrl_out   = ctrl_q;

endmodule

// File: tb/tb_simd_ex_stage.sv
// Self-checking bench for simd_ex_stage: random stimulus against
// an arithmetic reference model, plus directed timing scenarios.
module tb_simd_ex_stage;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int NFW    = 3;
  localparam int CTRL_W = 8;
  localparam int DW     = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              stall_in = 1'b0;
  logic              flush = 1'b0;
  logic [DW-1:0]     data1 = '0, data2 = '0, imm = '0;
  logic [NFW*DW-1:0] fw_data = '0;
  logic [1:0]        sel_fw_a = '0, sel_fw_b = '0;
  logic              alu_src = 1'b0;
  logic [2:0]        alu_op = '0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic              out_valid, busy;
  logic [DW-1:0]     alu_result, write_data;
  logic [CTRL_W-1:0] ctrl_out;

  int passed = 0;
  int total = 0;

  logic [DW-1:0]     last_res = '0, last_wd = '0;
  logic [CTRL_W-1:0] last_ctrl = '0;
  logic [DW-1:0]     e_res, e_wd;
  logic [CTRL_W-1:0] e_ctrl;

  always #5 clk = ~clk;

  simd_ex_stage #(
    .LANES(LANES), .LANE_W(LANE_W), .NFW(NFW), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .stall_in(stall_in), .flush(flush),
    .data1(data1), .data2(data2), .imm(imm), .fw_data(fw_data),
    .sel_fw_a(sel_fw_a), .sel_fw_b(sel_fw_b), .alu_src(alu_src),
    .alu_op(alu_op), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .alu_result(alu_result),
    .write_data(write_data), .ctrl_out(ctrl_out), .busy(busy)
  );

  function automatic logic [7:0] gf8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [DW-1:0] ref_op(input logic [2:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int unsigned x, y, s, v;
    r = '0;
    if (op == 3'd7) begin
      for (int i = 0; i < DW/8; i++) r[i*8 +: 8] = gf8(a[i*8 +: 8], b[i*8 +: 8]);
      return r;
    end
    for (int l = 0; l < LANES; l++) begin
      x = 32'(a[l*16 +: 16]);
      y = 32'(b[l*16 +: 16]);
      s = y % 16;
      case (op)
        3'd0: v = x + y;
        3'd1: v = x - y;
        3'd2: v = x & y;
        3'd3: v = x | y;
        3'd4: v = x ^ y;
        3'd5: v = x << s;
        3'd6: v = (x << s) | (x >> (16 - s));
        default: v = 0;
      endcase
      r[l*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [1:0] sel, input logic [DW-1:0] r);
    if (sel == 2'd0) return r;
    return fw_data[(int'(sel) - 1)*DW +: DW];
  endfunction

  // expected outputs from the currently driven inputs
  task automatic predict();
    logic [DW-1:0] a, bf, b;
    a  = fwd(sel_fw_a, data1);
    bf = fwd(sel_fw_b, data2);
    b  = alu_src ? imm : bf;
    e_res  = ref_op(alu_op, a, b);
    e_wd   = bf;
    e_ctrl = ctrl_in;
  endtask

  task automatic randomize_in(input logic [2:0] op);
    data1    = {$urandom, $urandom};
    data2    = {$urandom, $urandom};
    imm      = {$urandom, $urandom};
    fw_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    sel_fw_a = 2'($urandom_range(0, 3));
    sel_fw_b = 2'($urandom_range(0, 3));
    alu_src  = 1'($urandom_range(0, 1));
    ctrl_in  = 8'($urandom);
    alu_op   = op;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({out_valid, busy, alu_result, write_data, ctrl_out} !== '0)
      $display("FAIL reset: got v=%b b=%b r=%h w=%h c=%h want all 0",
               out_valid, busy, alu_result, write_data, ctrl_out);
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lane_isolation();
    randomize_in(3'd0);
    sel_fw_a = 2'd3;
    sel_fw_b = 2'd0;
    fw_data[2*DW +: DW] = 64'h0001_0002_0003_FFFF;
    alu_src = 1'b1;
    imm = 64'h0001_0001_0001_0001;
    tick();
    total++;
    if ({out_valid, alu_result, write_data} !== {1'b1, 64'h0002_0003_0004_0000, data2})
      $display("FAIL lane_iso: got v=%b r=%h w=%h want v=1 r=0002000300040000 w=%h",
               out_valid, alu_result, write_data, data2);
    else passed++;
    last_res = 64'h0002_0003_0004_0000; last_wd = data2; last_ctrl = ctrl_in;
    in_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, alu_result} !== {1'b0, last_res})
      $display("FAIL bubble: got v=%b r=%h want v=0 r=%h", out_valid, alu_result, last_res);
    else passed++;
  endtask

  task automatic test_rotate();
    logic [2:0] ops [2];
    logic [15:0] want [2];
    ops[0] = 3'd6; want[0] = 16'h0003;
    ops[1] = 3'd5; want[1] = 16'h0002;
    for (int i = 0; i < 2; i++) begin
      randomize_in(ops[i]);
      sel_fw_a = 2'd0;
      alu_src = 1'b1;
      data1[15:0] = 16'h8001;
      imm[15:0] = 16'd17;
      predict();
      tick();
      total++;
      if (alu_result[15:0] !== want[i] || alu_result !== e_res || out_valid !== 1'b1)
        $display("FAIL shift_op%0d: got v=%b r=%h want v=1 r=%h lane0=%h",
                 ops[i], out_valid, alu_result, e_res, want[i]);
      else passed++;
      last_res = e_res; last_wd = e_wd; last_ctrl = e_ctrl;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_ops();
    logic v;
    for (int n = 0; n < 40; n++) begin
      randomize_in(3'($urandom_range(0, 6)));
      v = ($urandom_range(0, 3) != 0);
      in_valid = v;
      predict();
      if (v) begin
        last_res = e_res; last_wd = e_wd; last_ctrl = e_ctrl;
      end
      tick();
      total++;
      if ({out_valid, alu_result, write_data, ctrl_out} !==
          {v, last_res, last_wd, last_ctrl})
        $display("FAIL random_op%0d: got v=%b r=%h w=%h c=%h want v=%b r=%h w=%h c=%h",
                 alu_op, out_valid, alu_result, write_data, ctrl_out,
                 v, last_res, last_wd, last_ctrl);
      else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_gfmul();
    logic [DW-1:0] add_res;
    randomize_in(3'd7);
    sel_fw_a = 2'd0; sel_fw_b = 2'd0; alu_src = 1'b0;
    data1 = {8{8'h57}};
    data2 = {8{8'h83}};
    last_wd = data2; last_ctrl = ctrl_in;
    tick();
    randomize_in(3'd0);
    predict();
    add_res = e_res;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL gf_busy_e%0d: got busy=%b v=%b want busy=1 v=0", i, busy, out_valid);
      else passed++;
      tick();
    end
    last_res = {8{8'hC1}};
    total++;
    if ({busy, out_valid, alu_result, write_data, ctrl_out} !==
        {1'b0, 1'b1, last_res, last_wd, last_ctrl})
      $display("FAIL gf_result: got busy=%b v=%b r=%h w=%h want busy=0 v=1 r=%h w=%h",
               busy, out_valid, alu_result, write_data, last_res, last_wd);
    else passed++;
    tick();
    last_res = add_res; last_wd = e_wd; last_ctrl = e_ctrl;
    total++;
    if ({out_valid, alu_result, write_data} !== {1'b1, last_res, last_wd})
      $display("FAIL gf_next_add: got v=%b r=%h w=%h want v=1 r=%h w=%h",
               out_valid, alu_result, write_data, last_res, last_wd);
    else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [DW-1:0] g_res, g_wd;
    logic [CTRL_W-1:0] g_ctrl;
    randomize_in(3'd1);
    predict();
    last_res = e_res; last_wd = e_wd; last_ctrl = e_ctrl;
    tick();
    randomize_in(3'd2);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({out_valid, alu_result, write_data, ctrl_out} !==
          {1'b1, last_res, last_wd, last_ctrl})
        $display("FAIL stall_hold%0d: got v=%b r=%h want v=1 r=%h",
                 i, out_valid, alu_result, last_res);
      else passed++;
    end
    stall_in = 1'b0;
    randomize_in(3'd7);
    predict();
    g_res = e_res; g_wd = e_wd; g_ctrl = e_ctrl;
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      stall_in = (e >= 4 && e <= 6);
      tick();
      if (e < 11) begin
        total++;
        if ({busy, out_valid, alu_result} !== {1'b1, 1'b0, last_res})
          $display("FAIL gf_stall_e%0d: got busy=%b v=%b r=%h want busy=1 v=0 r=%h",
                   e, busy, out_valid, alu_result, last_res);
        else passed++;
      end
    end
    stall_in = 1'b0;
    last_res = g_res; last_wd = g_wd; last_ctrl = g_ctrl;
    total++;
    if ({busy, out_valid, alu_result, write_data, ctrl_out} !==
        {1'b0, 1'b1, last_res, last_wd, last_ctrl})
      $display("FAIL gf_stall_result: got busy=%b v=%b r=%h w=%h want v=1 r=%h w=%h",
               busy, out_valid, alu_result, write_data, last_res, last_wd);
    else passed++;
  endtask

  task automatic test_flush();
    randomize_in(3'd7);
    tick();
    in_valid = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    randomize_in(3'd4);
    flush = 1'b1;
    tick();
    total++;
    if ({busy, out_valid, alu_result} !== {1'b0, 1'b0, last_res})
      $display("FAIL flush: got busy=%b v=%b r=%h want busy=0 v=0 r=%h",
               busy, out_valid, alu_result, last_res);
    else passed++;
    flush = 1'b0;
    predict();
    last_res = e_res; last_wd = e_wd; last_ctrl = e_ctrl;
    tick();
    total++;
    if ({out_valid, alu_result, write_data, ctrl_out} !==
        {1'b1, last_res, last_wd, last_ctrl})
      $display("FAIL flush_xor: got v=%b r=%h w=%h want v=1 r=%h w=%h",
               out_valid, alu_result, write_data, last_res, last_wd);
    else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_random_gf();
    for (int n = 0; n < 3; n++) begin
      randomize_in(3'd7);
      predict();
      last_res = e_res; last_wd = e_wd; last_ctrl = e_ctrl;
      tick();
      in_valid = 1'b0;
      for (int e = 1; e <= 8; e++) tick();
      total++;
      if ({out_valid, alu_result, write_data, ctrl_out} !==
          {1'b1, last_res, last_wd, last_ctrl})
        $display("FAIL random_gf%0d: got v=%b r=%h w=%h want v=1 r=%h w=%h",
                 n, out_valid, alu_result, write_data, last_res, last_wd);
      else passed++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    randomize_in(3'd7);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, busy, alu_result, write_data, ctrl_out} !== '0)
      $display("FAIL async_reset: got v=%b b=%b r=%h w=%h c=%h want all 0",
               out_valid, busy, alu_result, write_data, ctrl_out);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    randomize_in(3'd0);
    predict();
    tick();
    total++;
    if ({out_valid, busy, alu_result, write_data} !== {1'b1, 1'b0, e_res, e_wd})
      $display("FAIL post_reset_add: got v=%b r=%h w=%h want v=1 r=%h w=%h",
               out_valid, alu_result, write_data, e_res, e_wd);
    else passed++;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lane_isolation();
    test_rotate();
    test_random_ops();
    test_gfmul();
    test_stall();
    test_flush();
    test_random_gf();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simd_ex_stage.md
# simd_ex_stage

Parametrised SIMD execute stage for the AES datapath: operand forwarding, lane-wise ALU, and a registered EX/MEM output with valid, stall and flush control. It generalises the single-cycle 64-bit EX stage to `LANES` × `LANE_W` vectors and adds an iterative, multi-cycle GF(2^8) byte multiply for MixColumns. It sits between the ID/EX register and the MEM stage, and requests an upstream stall while the multiply is in progress.

## Interface
- `LANES`, 4, number of lanes
- `LANE_W`, 16, lane width in bits; must be a multiple of 8
- `NFW`, 3, number of forwarding sources
- `CTRL_W`, 8, width of the control bundle passed through unchanged (rd, reg/mem write flags)
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `in_valid` in 1: instruction present at the inputs
- `stall_in` in 1: downstream stall
- `flush` in 1: synchronous kill
- `data1`, `data2`, `imm` in DW (DW = LANES·LANE_W): register operands and immediate
- `fw_data` in NFW×DW, packed: forwarding sources
- `sel_fw_a`, `sel_fw_b` in FSW (FSW = $clog2(NFW+1)): 0 selects the register operand; k selects `fw_data[k-1]`
- `alu_src` in 1: 1 selects `imm` as operand B
- `alu_op` in 3: operation (see package)
- `ctrl_in` in CTRL_W: control bundle
- `out_valid` out 1: registered valid
- `alu_result` out DW: registered result
- `write_data` out DW: registered, forwarded B value taken before the immediate mux
- `ctrl_out` out CTRL_W: registered `ctrl_in`
- `busy` out 1: registered; GF multiply in progress, upstream must hold

## Operation
- Operand A is `fwA(data1)`. B_fw is `fwB(data2)`. B is `imm` when `alu_src`=1, otherwise B_fw. An out-of-range select yields 0.
- accept = `in_valid & !busy & !stall_in & !flush`.
- Ops, lane-wise with no carry or shift across lanes:
  - ADD, SUB, AND, OR, XOR: modulo 2^LANE_W.
  - SLL: shift left by the low log2(LANE_W) bits of the B lane.
  - ROTL: rotate left by the same amount.
  - GFMUL: byte-wise GF(2^8) product, polynomial 0x11B, over all DW/8 bytes.
- FSM states are IDLE and GF. `busy` = (state==GF).
  - IDLE → GF: on accept with GFMUL. Latches A, B, B_fw and `ctrl_in`; clears `acc`; sets `cnt`=0.
  - In GF, each non-stalled cycle performs one shift-and-add step per byte: if b[0] then acc ^= a; a = xtime(a); b >>= 1; cnt++.
  - When the step with `cnt`==7 executes: write `acc` to `alu_result`, set `out_valid`=1, return to IDLE.
  - In GF with `stall_in`=1: steps and output are frozen.
- Output register, priority order:
  1. `flush`: `out_valid`←0, FSM←IDLE, `cnt`←0. Data registers are unchanged.
  2. `stall_in`: hold all outputs.
  3. GF completion: load the result.
  4. Accept of a non-GF op: load the result, `out_valid`←1.
  5. Otherwise: `out_valid`←0 (bubble). This includes the accept cycle of GFMUL and the GF cycles before completion.
- Reset: all outputs and state = 0, FSM=IDLE. Takes effect immediately, including mid-GF.

## Timing
- Non-GF ops: 1-cycle latency. Inputs at edge E0 appear at the outputs after E0. Throughput 1/cycle.
- GFMUL: accepted at E0; `busy`=1 after E0 through E8; result and `out_valid` appear after E8, 8 cycles of latency. The next instruction is accepted at E9 at the earliest. Each stall cycle adds 1 cycle.
- `busy` is registered only. During the acceptance cycle of a GFMUL, upstream has already advanced; the next instruction then waits on `busy`.
- Forwarding sources are sampled only at acceptance. The GF engine works from its latched copies.

## Structure
- Package `simd_pkg`:
  - `alu_op_e`: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, ROTL=6, GFMUL=7
  - `ex_state_e`
  - constant `GF_POLY`=8'h1B
  - function `xtime`
- Sub-module `simd_lane_alu`: combinational, one lane, ops 0–6. Instantiated LANES times in a generate loop.
- The GF engine, forwarding muxes and output register live in the top level.

## Test plan
- Lane isolation: `sel_fw_a`=3, `fw_data[2]`=0x0001_0002_0003_FFFF, `alu_src`=1, `imm`=0x0001_0001_0001_0001, ADD → `alu_result`=0x0002_0003_0004_0000 one cycle later, `out_valid`=1; `write_data`=`data2`.
- Rotate: ROTL, A lane0=0x8001, B lane0=17 → lane0=0x0003. SLL by 17 → 0x0002.
- GFMUL: all bytes A=0x57, B=0x83 → every byte 0xC1. `busy`=1 for 8 cycles; `out_valid` pulses 1 cycle after E8. Following ADD is accepted at E9.
- Stall: `stall_in`=1 for 3 cycles during GF → result after E11; outputs held unchanged during the stall.
- Flush mid-GF at cycle 4 → `busy`=0 and `out_valid`=0 next cycle; a new XOR is accepted the following cycle and produces the correct result.
- Async reset: `rst_n` low mid-GF, between edges → all outputs 0 immediately. After release, an ADD executes normally.
